// File: rtl/gcd_scheduler_if.sv
// Bundle between the GCD scheduler and its environment: requester operand ports,
// the shared GCD engine start/done handshake and the tagged response channel.
interface gcd_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 7
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;

  logic              gcd_start;
  logic [W-1:0]      gcd_x;
  logic [W-1:0]      gcd_y;
  logic              gcd_done;
  logic [W-1:0]      gcd_result;

  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              rsp_ready;

  logic              busy;

  modport master (
    input  req_valid, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    output req_ready, gcd_start, gcd_x, gcd_y, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    output req_valid, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    input  req_ready, gcd_start, gcd_x, gcd_y, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/gcd_scheduler.sv
// Round-robin share of one GCD engine; accept->start 1 cycle, done->rsp 1 cycle, zero bypass 1 cycle.
// Backpressure: rsp held until rsp_ready; no new grant until the response handshake completes.
module gcd_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 7,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  gcd_scheduler_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = 10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic          any_req;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic [CW-1:0] wd_cnt;

  // Walk the ring downward so the closest valid requester at/after ptr is the last write.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[IW'((int'(ptr) + k) % NREQ)]) begin
        grant   = IW'((int'(ptr) + k) % NREQ);
        any_req = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IW'(i)) begin
        sel_a = bus.req_a[i*W +: W];
        sel_b = bus.req_b[i*W +: W];
      end
    end
  end

  assign bus.req_ready = (rst && state == IDLE && any_req) ? (NREQ'(1) << grant) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= '0;
      wd_cnt        <= '0;
      bus.gcd_start <= 1'b0;
      bus.gcd_x     <= '0;
      bus.gcd_y     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.gcd_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.gcd_x  <= sel_a;
            bus.gcd_y  <= sel_b;
            bus.rsp_id <= grant;
            bus.busy   <= 1'b1;
            // gcd(0,b)=b and gcd(a,0)=a, so OR gives the answer without the engine
            if (sel_a == '0 || sel_b == '0) begin
              bus.rsp_data  <= sel_a | sel_b;
              bus.rsp_err   <= 1'b0;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.gcd_start <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (bus.gcd_done) begin
            bus.rsp_data  <= bus.gcd_result;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            ptr           <= (bus.rsp_id == IW'(NREQ - 1)) ? '0 : bus.rsp_id + 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Round-robin scheduler that shares one GCD engine among `NREQ` requesters. It accepts one operand pair at a time and sequences the engine through a start/done handshake. Each result is returned to its owning requester with the requester ID. Zero operands bypass the engine, and a watchdog bounds engine latency. It sits between the operand FIFOs and the GCD datapath.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 7: operand/result width.
- `TIMEOUT`, 255: maximum engine cycles before abort (1..1023).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operand pair valid.
- `req_a`  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- `req_b`  in  NREQ*W  operand B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot acceptance pulse.
- `gcd_start`  out  1  one-cycle engine start.
- `gcd_x`  out  W  engine operand x.
- `gcd_y`  out  W  engine operand y.
- `gcd_done`  in  1  engine completion pulse.
- `gcd_result`  in  W  engine result, valid with `gcd_done`.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  $clog2(NREQ)  owning requester.
- `rsp_data`  out  W  GCD result.
- `rsp_err`  out  1  timeout flag.
- `rsp_ready`  in  1  response consumer ready.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, grant the first requester at or after `ptr`, searching circularly.
  - Capture its A/B into internal registers.
  - Pulse `req_ready[grant]` combinationally in this cycle; the requester treats valid&ready as the transfer.
  - Next state: RESP if A==0 or B==0, otherwise ISSUE.
- **Zero bypass:** `rsp_data` = A|B, so gcd(0,b)=b, gcd(a,0)=a and gcd(0,0)=0. `rsp_err`=0.
- **ISSUE:**
  - `gcd_start`=1 for exactly one cycle.
  - Go to WAIT and clear the watchdog counter.
- **`gcd_x`/`gcd_y`:** driven from the captured registers and held stable from ISSUE through WAIT.
- **WAIT:**
  - Counter increments every cycle.
  - On `gcd_done`, register `gcd_result` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - If the counter reaches TIMEOUT-1 without `gcd_done`, set `rsp_data`=0 and `rsp_err`=1, go to RESP.
  - If `gcd_done` and the timeout coincide, `gcd_done` wins.
- **RESP:**
  - `rsp_valid`=1. `rsp_id`/`rsp_data`/`rsp_err` are held stable until `rsp_ready`.
  - On `rsp_valid`&`rsp_ready`: `ptr` = grant+1 (wraps NREQ-1 to 0), go to IDLE.
- **Fairness:** `ptr` advances only on response completion. A requester keeps its request asserted until it sees `req_ready`.
- **Ignored inputs:** `gcd_done` outside WAIT. Requests outside IDLE are not accepted.
- **Reset (`rst`=0)**, at any time including mid-WAIT: state=IDLE, `ptr`=0.
  - Outputs: `req_ready`=0, `gcd_start`=0, `gcd_x`=0, `gcd_y`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0.
  - An in-flight request is dropped with no response.

## Timing
- **Accept to `gcd_start`:** 1 cycle. Accept in IDLE at cycle t; ISSUE at t+1.
- **`gcd_done` to `rsp_valid`:** 1 cycle.
- **Bypass path:** accept at t, `rsp_valid` at t+1.
- **Timeout path:** `rsp_valid` rises TIMEOUT+1 cycles after `gcd_start`.
- **Back-to-back:** the next accept happens at the earliest in the cycle after the response handshake, in IDLE. Per-request overhead is 3 cycles plus engine latency.
- **Registered outputs:** `gcd_start`, `gcd_x`, `gcd_y`, `rsp_*`, `busy`. `req_ready` is combinational from state, `req_valid` and `ptr`.

## Test plan
- **Single request:** requester 2 sends A=12, B=18 and the engine model returns 6 after 10 cycles.
  - `req_ready`=4'b0100 for one cycle; `gcd_start` pulses once with x=12, y=18.
  - `rsp_valid` with id=2, data=6, err=0 one cycle after done.
- **Round-robin:** all 4 requesters hold `req_valid`.
  - Grant order is 0,1,2,3,0.
  - Holding `rsp_ready`=0 for 5 cycles on the first response keeps `rsp_*` stable and blocks the next grant.
- **Zero bypass:** (0,35) returns 35; (42,0) returns 42; (0,0) returns 0.
  - `gcd_start` never asserts; `rsp_valid` appears 1 cycle after accept.
- **Timeout:** TIMEOUT=8 and the engine never raises `gcd_done`.
  - `rsp_err`=1 and `rsp_data`=0, 9 cycles after `gcd_start`.
  - A late `gcd_done` afterwards is ignored.
- **Coincident done/timeout:** `gcd_done` (result 5) arrives on the timeout cycle. Response data=5, err=0.
- **Reset mid-operation:** `rst` is asserted low during WAIT.
  - All outputs go to 0 immediately and `ptr`=0.
  - After release, requester 0 is served first when 0 and 3 both request.
